// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: synchronizes the PS/2 lines, frames and checks bytes,
// tracks prefixes and modifiers, maps make codes to ASCII and queues events in a FWFT FIFO.
module ps2_kbd_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_MS = 20,
    parameter int FIFO_DEPTH = 8,
    parameter bit PUSH_BREAK = 1'b0,
    parameter bit PUSH_RAW   = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps_clock,
    input  logic       ps_data,
    input  logic       rd,
    input  logic       clr_ovf,
    output logic       valid,
    output logic [7:0] ascii,
    output logic [7:0] scancode,
    output logic       released,
    output logic       extended,
    output logic [2:0] mods,
    output logic       overflow,
    output logic       parity_err
);
    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [31:0] TO_CYC = 32'(CLK_HZ / 1000 * TIMEOUT_MS);

    typedef struct packed {
        logic       released;
        logic       extended;
        logic [7:0] scancode;
        logic [7:0] ascii;
    } kev_t;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    function automatic logic [7:0] letter_of(input logic [7:0] code);
        logic [7:0] l;
        case (code)
            8'h1C: l = "a";  8'h32: l = "b";  8'h21: l = "c";  8'h23: l = "d";
            8'h24: l = "e";  8'h2B: l = "f";  8'h34: l = "g";  8'h33: l = "h";
            8'h43: l = "i";  8'h3B: l = "j";  8'h42: l = "k";  8'h4B: l = "l";
            8'h3A: l = "m";  8'h31: l = "n";  8'h44: l = "o";  8'h4D: l = "p";
            8'h15: l = "q";  8'h2D: l = "r";  8'h1B: l = "s";  8'h2C: l = "t";
            8'h3C: l = "u";  8'h2A: l = "v";  8'h1D: l = "w";  8'h22: l = "x";
            8'h35: l = "y";  8'h1A: l = "z";
            default: l = 8'h00;
        endcase
        return l;
    endfunction

    function automatic logic [7:0] key_ascii(input logic [7:0] code, input logic ext,
                                             input logic sh, input logic ct, input logic cp);
        logic [7:0] lc, a;
        lc = letter_of(code);
        a  = 8'h00;
        if (ext) begin
            case (code)
                8'h7D: a = 8'h01;  8'h7A: a = 8'h02;  8'h75: a = 8'h03;  8'h74: a = 8'h04;
                8'h72: a = 8'h05;  8'h6B: a = 8'h06;  8'h71: a = 8'h07;  8'h6C: a = 8'h0B;
                8'h70: a = 8'h0C;  8'h69: a = 8'h0D;
                default: a = 8'h00;
            endcase
        end else if (lc != 8'h00) begin
            if (ct)           a = lc & 8'h1F;
            else if (sh ^ cp) a = lc - 8'h20;
            else              a = lc;
        end else begin
            case (code)
                8'h16: a = sh ? "!" : "1";      8'h1E: a = sh ? "@" : "2";
                8'h26: a = sh ? "#" : "3";      8'h25: a = sh ? "$" : "4";
                8'h2E: a = sh ? "%" : "5";      8'h36: a = sh ? "^" : "6";
                8'h3D: a = sh ? "&" : "7";      8'h3E: a = sh ? "*" : "8";
                8'h46: a = sh ? "(" : "9";      8'h45: a = sh ? ")" : "0";
                8'h0E: a = sh ? "~" : 8'h60;    8'h4E: a = sh ? "_" : "-";
                8'h55: a = sh ? "+" : "=";      8'h54: a = sh ? "{" : "[";
                8'h5B: a = sh ? "}" : "]";      8'h5D: a = sh ? 8'h7C : 8'h5C;
                8'h4C: a = sh ? ":" : ";";      8'h52: a = sh ? 8'h22 : 8'h27;
                8'h41: a = sh ? "<" : ",";      8'h49: a = sh ? ">" : ".";
                8'h4A: a = sh ? "?" : "/";
                8'h66: a = 8'h08;  8'h0D: a = 8'h09;  8'h5A: a = 8'h0A;
                8'h76: a = 8'h1B;  8'h29: a = 8'h20;
                default: a = 8'h00;
            endcase
        end
        return a;
    endfunction

    logic [1:0]  clk_sync, dat_sync;
    logic        clk_prev, fall;
    state_t      state, state_nxt;
    logic [3:0]  bit_cnt;
    logic [10:0] sr;
    logic [31:0] to_cnt;
    logic        timeout;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps_clock};
            dat_sync <= {dat_sync[0], ps_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[1];
    assign timeout = (state == RECV) && clk_sync[1] && (to_cnt >= TO_CYC);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // The start bit is captured on the falling edge that leaves IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = RECV;
            RECV:    if (timeout) state_nxt = IDLE;
                     else if (fall && bit_cnt == 4'd9) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr      <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (fall && (state == IDLE || state == RECV)) begin
                sr      <= {dat_sync[1], sr[10:1]};
                bit_cnt <= (state == IDLE) ? 4'd0 : bit_cnt + 4'd1;
            end
            if (state != RECV || !clk_sync[1]) to_cnt <= '0;
            else                               to_cnt <= to_cnt + 32'd1;
        end
    end

    logic       frame_ok, acc, is_key, is_mod, push;
    logic [7:0] code, asc;
    logic       brk_pend, ext_pend, shift, ctrl, caps;

    assign code     = sr[8:1];
    assign frame_ok = ~sr[0] & sr[10] & (^sr[9:1]);
    assign acc      = (state == CHECK) & frame_ok;
    assign is_key   = acc && code != 8'hF0 && code != 8'hE0;
    assign is_mod   = (!ext_pend && (code == 8'h12 || code == 8'h59 || code == 8'h58)) || code == 8'h14;
    assign asc      = brk_pend ? 8'h00 : key_ascii(code, ext_pend, shift, ctrl, caps);
    assign push     = is_key && (!brk_pend || PUSH_BREAK) && (asc != 8'h00 || PUSH_RAW)
                      && (!is_mod || PUSH_RAW);

    kev_t ev;
    logic ev_push;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            shift      <= 1'b0;
            ctrl       <= 1'b0;
            caps       <= 1'b0;
            ev_push    <= 1'b0;
            ev         <= '0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= (state == CHECK) & ~frame_ok;
            ev_push    <= push;
            if (push) ev <= kev_t'{brk_pend, ext_pend, code, asc};
            if (acc) begin
                if (code == 8'hF0)      brk_pend <= 1'b1;
                else if (code == 8'hE0) ext_pend <= 1'b1;
                else begin
                    brk_pend <= 1'b0;
                    ext_pend <= 1'b0;
                    if (!ext_pend && (code == 8'h12 || code == 8'h59)) shift <= ~brk_pend;
                    if (code == 8'h14) ctrl <= ~brk_pend;
                    if (!ext_pend && code == 8'h58 && !brk_pend) caps <= ~caps;
                end
            end
        end
    end

    kev_t        mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic        empty, full, pop, wr, drop;
    kev_t        head;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = rd & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign wr    = ev_push & (~full | pop);
    assign drop  = ev_push & full & ~pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp[AW-1:0]] <= ev;
                wp              <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign head     = mem[rp[AW-1:0]];
    assign valid    = ~empty;
    assign ascii    = head.ascii;
    assign scancode = head.scancode;
    assign released = head.released;
    assign extended = head.extended;
    assign mods     = {caps, ctrl, shift};
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Directed bench for ps2_kbd_fifo: expected events go into a scoreboard queue,
// a monitor pops and compares them as the FIFO presents entries.
module tb_ps2_kbd_fifo;
    localparam int CLK_HZ     = 100000;
    localparam int TIMEOUT_MS = 20;
    localparam int TO_CYC     = 2000;
    localparam int HALF       = 6;

    logic       clock, reset_n, ps_clock, ps_data, rd, clr_ovf;
    logic       valid, released, extended, overflow, parity_err;
    logic [7:0] ascii, scancode;
    logic [2:0] mods;

    ps2_kbd_fifo #(
        .CLK_HZ(CLK_HZ), .TIMEOUT_MS(TIMEOUT_MS), .FIFO_DEPTH(8),
        .PUSH_BREAK(1'b0), .PUSH_RAW(1'b0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .ps_clock(ps_clock), .ps_data(ps_data),
        .rd(rd), .clr_ovf(clr_ovf), .valid(valid), .ascii(ascii), .scancode(scancode),
        .released(released), .extended(extended), .mods(mods), .overflow(overflow),
        .parity_err(parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [17:0] sb[$];
    logic [17:0] e;
    int          n_vec = 0, n_err = 0, perr_cnt = 0;
    bit          auto_pop = 1'b0, man_rd = 1'b0;
    logic [7:0]  fill_code [11] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                                    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // rd driver: drain automatically, or follow the manual request.
    initial begin
        rd = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            rd = auto_pop ? valid : man_rd;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (parity_err) perr_cnt++;
            if (valid && rd) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: got %0h want none",
                             {released, extended, scancode, ascii});
                end else begin
                    e = sb.pop_front();
                    chk("event", 32'({released, extended, scancode, ascii}), 32'(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic exp_ev(input logic rel, input logic ext, input logic [7:0] sc, input logic [7:0] as);
        sb.push_back({rel, ext, sc, as});
    endtask

    // mode 1: check write latency; 2: rd during the write cycle; 3: clr_ovf during the write cycle
    task automatic send_bits(input logic [10:0] f, input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            ps_data = f[i];
            repeat (HALF) @(negedge clock);
            ps_clock = 1'b0;
            if (i == 10 && mode != 0) begin
                repeat (3) @(posedge clock);
                if (mode == 2) begin @(negedge clock); man_rd = 1'b1; end
                if (mode == 3) begin @(negedge clock); clr_ovf = 1'b1; end
                @(posedge clock);
                #1;
                if (mode == 1) chk("lat_c1_not_valid", 32'(valid), 32'd0);
                if (mode >= 2) begin @(negedge clock); man_rd = 1'b0; clr_ovf = 1'b0; end
                @(posedge clock);
                #1;
                if (mode == 1) chk("lat_c2_valid", 32'(valid), 32'd1);
            end
            repeat (HALF) @(negedge clock);
            ps_clock = 1'b1;
        end
    endtask

    task automatic send_key(input logic [7:0] b);
        send_bits(frame(b, 1'b0), 11, 0);
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clock);
        chk(name, 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clock);
        chk({name, "_empty"}, 32'(valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_ascii_scan"}, 32'({ascii, scancode}), 32'd0);
        chk({tag, "_rel_ext"}, 32'({released, extended}), 32'd0);
        chk({tag, "_mods"}, 32'(mods), 32'd0);
        chk({tag, "_ovf_perr"}, 32'({overflow, parity_err}), 32'd0);
    endtask

    int p0;

    initial begin
        reset_n = 1'b0; ps_clock = 1'b1; ps_data = 1'b1; clr_ovf = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset_n  = 1'b1;
        auto_pop = 1'b1;
        repeat (3) @(negedge clock);

        // single make with latency, then a break that must queue nothing
        exp_ev(1'b0, 1'b0, 8'h1C, 8'h61);
        send_bits(frame(8'h1C, 1'b0), 11, 1);
        wait_drain("make_1c");
        send_key(8'hF0);
        send_key(8'h1C);
        wait_drain("break_1c");

        // shift, caps, ctrl
        send_key(8'h12);
        chk("shift_on", 32'(mods), 32'd1);
        exp_ev(1'b0, 1'b0, 8'h1C, 8'h41); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h12);
        chk("shift_off", 32'(mods), 32'd0);
        exp_ev(1'b0, 1'b0, 8'h1C, 8'h61); send_key(8'h1C);
        send_key(8'h58);
        chk("caps_on", 32'(mods), 32'd4);
        exp_ev(1'b0, 1'b0, 8'h1C, 8'h41); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h58);
        chk("caps_break_noop", 32'(mods), 32'd4);
        send_key(8'h58);
        chk("caps_off", 32'(mods), 32'd0);
        send_key(8'h14);
        chk("ctrl_on", 32'(mods), 32'd2);
        exp_ev(1'b0, 1'b0, 8'h1C, 8'h01); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h14);
        send_key(8'h59);
        exp_ev(1'b0, 1'b0, 8'h16, 8'h21); send_key(8'h16);
        send_key(8'hF0); send_key(8'h59);
        chk("rshift_off", 32'(mods), 32'd0);
        exp_ev(1'b0, 1'b0, 8'h16, 8'h31); send_key(8'h16);
        exp_ev(1'b0, 1'b0, 8'h4A, 8'h2F); send_key(8'h4A);
        exp_ev(1'b0, 1'b0, 8'h5A, 8'h0A); send_key(8'h5A);
        wait_drain("mods");

        // extended keys
        exp_ev(1'b0, 1'b1, 8'h75, 8'h03);
        send_key(8'hE0); send_key(8'h75);
        send_key(8'hE0); send_key(8'h14);
        chk("rctrl_on", 32'(mods), 32'd2);
        send_key(8'hE0); send_key(8'hF0); send_key(8'h14);
        chk("rctrl_off", 32'(mods), 32'd0);
        wait_drain("extended");

        // bad parity
        p0 = perr_cnt;
        send_bits(frame(8'h1C, 1'b1), 11, 0);
        repeat (4) @(negedge clock);
        chk("parity_pulse", 32'(perr_cnt - p0), 32'd1);
        wait_drain("bad_parity");

        // stalled partial frame, then a clean one
        p0 = perr_cnt;
        send_bits(frame(8'h1C, 1'b0), 5, 0);
        repeat (TO_CYC + 20) @(negedge clock);
        exp_ev(1'b0, 1'b0, 8'h16, 8'h31); send_key(8'h16);
        chk("timeout_no_perr", 32'(perr_cnt - p0), 32'd0);
        wait_drain("timeout");

        // fill, overflow, simultaneous write/pop, clear
        auto_pop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_ev(1'b0, 1'b0, fill_code[i], 8'h61 + 8'(i));
            send_key(fill_code[i]);
        end
        chk("full_no_ovf", 32'(overflow), 32'd0);
        exp_ev(1'b0, 1'b0, fill_code[8], 8'h69);
        send_bits(frame(fill_code[8], 1'b0), 11, 2);
        repeat (4) @(negedge clock);
        chk("wr_pop_full_ovf", 32'(overflow), 32'd0);
        send_key(fill_code[9]);
        chk("drop_ovf_set", 32'(overflow), 32'd1);
        @(negedge clock); clr_ovf = 1'b1;
        @(negedge clock); clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        send_bits(frame(fill_code[10], 1'b0), 11, 3);
        repeat (4) @(negedge clock);
        chk("drop_beats_clr", 32'(overflow), 32'd1);
        auto_pop = 1'b1;
        wait_drain("fifo_fill");
        @(negedge clock); clr_ovf = 1'b1;
        @(negedge clock); clr_ovf = 1'b0;

        // reset mid-frame with state pending
        auto_pop = 1'b0;
        send_key(8'h12);
        exp_ev(1'b0, 1'b0, 8'h1C, 8'h41); send_key(8'h1C);
        chk("pre_reset_valid", 32'(valid), 32'd1);
        send_key(8'hE0);
        send_bits(frame(8'h29, 1'b0), 6, 0);
        @(negedge clock); reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk_reset_outputs("midframe_reset");
        sb.delete();
        reset_n  = 1'b1;
        auto_pop = 1'b1;
        repeat (3) @(negedge clock);
        exp_ev(1'b0, 1'b0, 8'h29, 8'h20); send_key(8'h29);
        wait_drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_fifo.md
PS2_KBD_FIFO -- requirements
Module: ps2_kbd_fifo

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CLK_HZ, 25000000, clock frequency.
- TIMEOUT_MS, 20, stalled-frame abort time.
- FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..64.
- PUSH_BREAK, 0, 1 = also enqueue key-release events.
- PUSH_RAW, 0, 1 = also enqueue events whose ASCII is 00.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, the single clock; everything is synchronous to its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- ps_clock, in, 1, PS/2 clock, asynchronous.
- ps_data, in, 1, PS/2 data, asynchronous.
- rd, in, 1, pop head entry.
- clr_ovf, in, 1, clear the overflow flag.
- valid, out, 1, FIFO non-empty.
- ascii, out, 8, head entry ASCII.
- scancode, out, 8, head entry scancode.
- released, out, 1, head entry is a break.
- extended, out, 1, head entry carried the E0 prefix.
- mods, out, 3, live {caps, ctrl, shift}.
- overflow, out, 1, sticky: an event was dropped.
- parity_err, out, 1, one-cycle pulse per rejected frame.

Function
REQ-003 ps_clock and ps_data SHALL each pass through a 2-flop synchronizer; a falling edge is synchronized ps_clock going 1->0.
REQ-004 The receive FSM SHALL have states IDLE, RECV and CHECK.
- IDLE->RECV on a falling edge; bit counter = 0.
- In RECV, each falling edge samples ps_data into an 11-bit shift register, LSB first, and increments the counter.
- RECV->CHECK on the 11th sample.
REQ-005 In CHECK (one cycle), a frame SHALL be accepted only if start=0, stop=1 and bits[8:0] have odd parity; otherwise it is dropped, parity_err pulses, and the FSM returns to IDLE.
REQ-006 In RECV, if synchronized ps_clock stays high for more than CLK_HZ/1000*TIMEOUT_MS consecutive cycles (500000 at defaults), the FSM SHALL return to IDLE, discard partial bits, and leave prefix state unchanged.
REQ-007 Prefix and event handling for an accepted byte:
- F0 sets brk_pend.
- E0 sets ext_pend.
- Any other byte forms an event {brk_pend, ext_pend, code}; both pendings then clear.
REQ-008 Modifier tracking:
- Codes 12 and 59 (non-extended) set shift on make and clear it on break.
- 14 and E0 14 do the same for ctrl.
- 58 make toggles caps; 58 break has no effect.
REQ-009 ASCII mapping:
- Letters: uppercase if shift XOR caps; if ctrl, ASCII = letter & 1F.
- Digits and punctuation: US layout, shifted when shift=1.
- 66->08, 0D->09, 5A->0A, 76->1B, 29->20.
- Extended: 7D->01, 7A->02, 75->03, 74->04, 72->05, 6B->06, 71->07, 6C->0B, 70->0C, 69->0D.
- All other codes, and all break events, map to 00.
REQ-010 An event SHALL be enqueued only if all three hold:
- it is a make, or PUSH_BREAK=1;
- its ASCII is non-zero, or PUSH_RAW=1;
- it is not a modifier code, or PUSH_RAW=1.
REQ-011 Latency: with CHECK in cycle C, the FIFO write SHALL occur at the clock edge ending cycle C+1, and valid SHALL be high in cycle C+2 if the FIFO was empty.
REQ-012 The FIFO SHALL be first-word-fall-through. The outputs ascii, scancode, released and extended reflect the head entry whenever valid=1 and are don't-care otherwise.
REQ-013 rd with valid=1 SHALL pop one entry per cycle; rd with valid=0 SHALL be ignored.
REQ-014 Write while full without a same-cycle pop SHALL drop the event and set overflow. Simultaneous write and pop while full SHALL accept both.
REQ-015 clr_ovf SHALL clear overflow; if a drop occurs in the same cycle, overflow stays set.
REQ-016 Pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.

Reset
REQ-017 While reset_n=0, asynchronously:
- FSM = IDLE; counters and synchronizers cleared (synchronizers to 1).
- FIFO empty; valid = 0.
- ascii, scancode = 00; released, extended = 0.
- mods = 000; overflow = 0; parity_err = 0.
- brk_pend, ext_pend = 0.
REQ-018 Reset asserted mid-frame SHALL discard the frame. After deassertion, reception resumes at the next falling edge.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Frame 1C with valid parity -> valid=1, ascii=61, scancode=1C, released=0 at C+2; F0 1C -> nothing enqueued.
- 12, 1C, F0 12, 1C -> ascii 41 then 61; mods[0] reads 1 then 0. 58, 1C -> ascii 41, mods[2]=1.
- E0 75 -> ascii=03, extended=1. Frame 1C with bad parity -> parity_err pulse, nothing enqueued.
- 5 bits sent, then ps_clock held high for 500001 cycles -> FSM in IDLE; a following full 16 frame yields ascii=31.
- 9 events with no rd at FIFO_DEPTH=8 -> 8 entries, overflow=1. The 9th event arriving in the same cycle as rd -> accepted, overflow unchanged.
- reset_n pulsed low after bit 6 -> all outputs at reset values; the next frame 29 yields ascii=20.
